// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder
// Description : Bus-attached 16-bit RAM with a MAR, wait-stated access FSM
//               and an external loader port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  MAR_CTL,
  input  logic [1:0]  RAM_CTL,
  input  logic [15:0] BUS_IN,
  output logic [15:0] BUS_OUT,
  output logic        BUS_OE,
  output logic        RDY,
  output logic        BUSY,
  input  logic        EXT_RAM_EN,
  input  logic        EXT_RAM_RW,
  input  logic [15:0] ADDRESS,
  input  logic [15:0] DATA,
  output logic        ERR_OVR
);

  localparam int         c_DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_mar;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_dir;
  logic [15:0]         r_wdata;
  logic [3:0]          r_cnt;
  logic                r_err;
  logic                r_rdy;
  logic                r_oe;
  logic [15:0]         r_bus_out;
  logic [15:0]         r_mem [c_DEPTH];

  logic                w_idle;
  logic                w_req;
  logic                w_ext_wr;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [15:0]         w_mem_wdata;
  logic                w_unused_addr;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_req         = RAM_CTL[0];
  assign w_ext_wr      = EXT_RAM_EN && !EXT_RAM_RW;
  assign w_unused_addr = ^ADDRESS;

  // One write port shared by the FSM commit and the loader; they never
  // overlap because the loader is only honoured while idle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_addr;
    w_mem_wdata = r_wdata;
    if (!RST) begin
      if (r_state == ST_DONE && !r_dir) begin
        w_mem_we = 1'b1;
      end else if (w_idle && w_ext_wr) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = ADDRESS[ADDR_W-1:0];
        w_mem_wdata = DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_mar     <= '0;
      r_addr    <= '0;
      r_dir     <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rdy     <= 1'b0;
      r_oe      <= 1'b0;
      r_bus_out <= '0;
    end else begin
      r_rdy     <= 1'b0;
      r_oe      <= 1'b0;
      r_bus_out <= '0;
      if (MAR_CTL == 2'b01) begin
        r_mar <= BUS_IN[ADDR_W-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ext_wr) begin
            if (w_req) begin
              r_err <= 1'b1;
            end
          end else if (w_req) begin
            // r_mar here is the pre-load value even if MAR loads this edge
            r_addr  <= r_mar;
            r_dir   <= RAM_CTL[1];
            r_wdata <= BUS_IN;
            r_cnt   <= c_WAIT;
            r_state <= (c_WAIT == 4'd0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= ST_DONE;
          end
          if (w_req || EXT_RAM_EN) begin
            r_err <= 1'b1;
          end
        end
        ST_DONE: begin
          r_rdy <= 1'b1;
          if (r_dir) begin
            r_oe      <= 1'b1;
            r_bus_out <= r_mem[r_addr];
          end
          r_state <= ST_IDLE;
          if (w_req || EXT_RAM_EN) begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUS_OUT = r_bus_out;
  assign BUS_OE  = r_oe;
  assign RDY     = r_rdy;
  assign BUSY    = (r_state != ST_IDLE);
  assign ERR_OVR = r_err;

endmodule
`default_nettype wire

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter ADDR_W, default 8: memory address width; depth is 2**ADDR_W words of 16 bits.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states per RAM access; legal range 0-15.
REQ-003 CLK  in  1: single clock; all state updates on the rising edge.
REQ-004 RST  in  1: synchronous, active-high reset.
REQ-005 MAR_CTL  in  2: bit1 selects mode (0 = load MAR from bus, 1 = hold/present MAR); bit0 = enable.
REQ-006 RAM_CTL  in  2: bit1 selects direction (1 = read onto bus, 0 = write from bus); bit0 = enable.
REQ-007 BUS_IN  in  16: shared data bus as driven by other agents.
REQ-008 BUS_OUT  out  16: read data toward the shared bus.
REQ-009 BUS_OE  out  1: BUS_OUT is valid and must be gated onto the bus.
REQ-010 RDY  out  1: one-cycle pulse marking completion of a RAM access.
REQ-011 BUSY  out  1: high whenever the FSM is not IDLE.
REQ-012 EXT_RAM_EN, EXT_RAM_RW  in  1 each: external loader port; EXT_RAM_RW = 0 means write.
REQ-013 ADDRESS  in  16: external loader address; only bits [ADDR_W-1:0] are used.
REQ-014 DATA  in  16: external loader write data.
REQ-015 ERR_OVR  out  1: sticky flag for a request dropped while busy.

Function
REQ-016 MAR_CTL = 01: MAR <= BUS_IN[ADDR_W-1:0] at the same edge; upper bits are discarded.
REQ-017 MAR_CTL = 11, 10 or 00: MAR holds its value; MAR is never driven onto the bus.
REQ-018 FSM states: IDLE, WAIT, DONE.
REQ-019 IDLE, RAM_CTL[0] = 1: capture addr <= current MAR (the pre-load value if MAR loads in the same cycle), dir <= RAM_CTL[1], wdata <= BUS_IN; wait counter <= WAIT_CYCLES; go to WAIT, or to DONE when WAIT_CYCLES = 0.
REQ-020 WAIT: decrement the counter each cycle; go to DONE on the cycle the counter reaches 0.
REQ-021 DONE, write: mem[addr] <= wdata; RDY = 1 for this one cycle; return to IDLE.
REQ-022 DONE, read: BUS_OUT = mem[addr] and BUS_OE = 1 for exactly this one cycle; RDY = 1; return to IDLE.
REQ-023 Latency: RDY asserts WAIT_CYCLES+1 cycles after the edge that samples the request.
REQ-024 BUS_OE is 0 in all states other than a read DONE; BUS_OUT is 0 whenever BUS_OE = 0.
REQ-025 External port, IDLE with EXT_RAM_EN = 1 and EXT_RAM_RW = 0: mem[ADDRESS] <= DATA in one cycle; no RDY pulse, no bus drive.
REQ-026 External port, read (EXT_RAM_RW = 1): ignored; there is no external read path.
REQ-027 External write and RAM_CTL request in the same IDLE cycle: the external write wins; the controller request is dropped and ERR_OVR is set.
REQ-028 RAM_CTL[0] = 1 sampled in WAIT or DONE: request is ignored, ERR_OVR <= 1, and the in-flight access completes unchanged.
REQ-029 EXT_RAM_EN = 1 while not IDLE: ignored, ERR_OVR <= 1.
REQ-030 A new request in the cycle immediately after DONE (IDLE) is accepted normally; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-031 Address wrap: all address arithmetic is modulo 2**ADDR_W.
REQ-032 ERR_OVR clears only on reset.

Reset
REQ-033 When RST = 1 at an edge: FSM <= IDLE, MAR <= 0, counter <= 0, ERR_OVR <= 0; BUS_OE, RDY and BUSY read 0 from the next cycle.
REQ-034 Memory contents are not cleared by reset.
REQ-035 Reset mid-access aborts the access: a pending write is not committed and no RDY is pulsed.
REQ-036 RST overrides all inputs in the same cycle.

Verification
REQ-037 WAIT_CYCLES = 1: MAR_CTL = 01 with BUS_IN = 0x0012; then RAM_CTL = 01 with BUS_IN = 0xBEEF -> RDY 2 cycles later; a later read (RAM_CTL = 11) -> BUS_OE = 1 and BUS_OUT = 0xBEEF for one cycle.
REQ-038 Same-cycle MAR_CTL = 01 (BUS_IN = 0x0034) with RAM_CTL = 11, where MAR = 0x12 -> the access reads address 0x12, and MAR = 0x34 afterwards.
REQ-039 Loader: EXT_RAM_EN = 1, EXT_RAM_RW = 0, ADDRESS = 0x0105, DATA = 0x1234 with ADDR_W = 8 -> mem[0x05] = 0x1234; a controller read of 0x05 returns 0x1234.
REQ-040 RAM_CTL = 11 issued during WAIT -> ERR_OVR = 1, exactly one RDY pulse, original data returned.
REQ-041 RST = 1 during WAIT of a write of 0xAAAA to address 0x07 whose old value is 0x5555 -> no RDY; a subsequent read of address 0x07 returns 0x5555.
REQ-042 WAIT_CYCLES = 0: a read request -> BUS_OE and RDY on the next cycle; back-to-back reads complete every 2 cycles.
